// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared sizing parameters for the dispatch stage
// Purpose: nominal widths and depths used as defaults by dispatch_unit and its interface.
// Ports: none.
package params_pkg;
  parameter int REGISTER_WIDTH  = 5;
  parameter int ROB_ENTRIES     = 16;
  parameter int ROB_ENTRY_WIDTH = 4;
  parameter int ADDR_WIDTH      = 32;
endpackage

// File: rtl/dispatch_unit_if.sv
// rtl/dispatch_unit_if.sv - decode/ROB/commit/issue bundle for the dispatch stage
// Purpose: groups every handshake and payload signal of dispatch_unit.
// Ports: none; modport slave is the dispatch_unit view, modport master the environment view.
interface dispatch_unit_if #(
  parameter int REGISTER_WIDTH  = params_pkg::REGISTER_WIDTH,
  parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH
);
  // decode side
  logic                       dec_valid_i;
  logic                       dec_ready_o;
  logic [ADDR_WIDTH-1:0]      dec_pc_i;
  logic                       dec_is_wb_i;
  logic [REGISTER_WIDTH-1:0]  dec_rd_i;
  logic [REGISTER_WIDTH-1:0]  dec_rs1_i;
  logic [REGISTER_WIDTH-1:0]  dec_rs2_i;
  // ROB allocation
  logic                       rob_full_i;
  logic [ROB_ENTRY_WIDTH-1:0] rob_new_idx_i;
  logic                       rob_alloc_valid_o;
  logic                       rob_alloc_is_wb_o;
  logic [REGISTER_WIDTH-1:0]  rob_alloc_reg_id_o;
  logic [ADDR_WIDTH-1:0]      rob_alloc_pc_o;
  // ROB commit
  logic                       commit_valid_i;
  logic                       commit_is_wb_i;
  logic [REGISTER_WIDTH-1:0]  commit_reg_id_i;
  // issue side
  logic                       issue_valid_o;
  logic                       issue_ready_i;
  logic [ROB_ENTRY_WIDTH-1:0] issue_rob_idx_o;
  logic [ADDR_WIDTH-1:0]      issue_pc_o;
  logic [REGISTER_WIDTH-1:0]  issue_rd_o;
  logic                       issue_rs1_pending_o;
  logic                       issue_rs2_pending_o;
  logic [ROB_ENTRY_WIDTH-1:0] issue_rs1_tag_o;
  logic [ROB_ENTRY_WIDTH-1:0] issue_rs2_tag_o;

  modport slave (
    input  dec_valid_i, dec_pc_i, dec_is_wb_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
    input  rob_full_i, rob_new_idx_i,
    input  commit_valid_i, commit_is_wb_i, commit_reg_id_i,
    input  issue_ready_i,
    output dec_ready_o,
    output rob_alloc_valid_o, rob_alloc_is_wb_o, rob_alloc_reg_id_o, rob_alloc_pc_o,
    output issue_valid_o, issue_rob_idx_o, issue_pc_o, issue_rd_o,
    output issue_rs1_pending_o, issue_rs2_pending_o, issue_rs1_tag_o, issue_rs2_tag_o
  );

  modport master (
    output dec_valid_i, dec_pc_i, dec_is_wb_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
    output rob_full_i, rob_new_idx_i,
    output commit_valid_i, commit_is_wb_i, commit_reg_id_i,
    output issue_ready_i,
    input  dec_ready_o,
    input  rob_alloc_valid_o, rob_alloc_is_wb_o, rob_alloc_reg_id_o, rob_alloc_pc_o,
    input  issue_valid_o, issue_rob_idx_o, issue_pc_o, issue_rd_o,
    input  issue_rs1_pending_o, issue_rs2_pending_o, issue_rs1_tag_o, issue_rs2_tag_o
  );
endinterface

// File: rtl/dispatch_unit.sv
// rtl/dispatch_unit.sv - in-order dispatch stage with register alias table and issue register
// Purpose: allocates ROB entries, stalls decode on ROB full or issue back-pressure, tracks
//          the youngest in-flight producer of each architectural register, and presents each
//          dispatched instruction with source pending flags/tags through a registered slot.
// Ports: clk_i  - clock, rising edge
//        rst_i  - asynchronous active-high reset
//        bus    - dispatch_unit_if.slave: decode handshake, ROB alloc/commit, issue handshake
module dispatch_unit #(
  parameter int REGISTER_WIDTH  = params_pkg::REGISTER_WIDTH,
  parameter int ROB_ENTRIES     = params_pkg::ROB_ENTRIES,
  parameter int ROB_ENTRY_WIDTH = params_pkg::ROB_ENTRY_WIDTH,
  parameter int ADDR_WIDTH      = params_pkg::ADDR_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_i,
  dispatch_unit_if.slave  bus
);
  localparam int NUM_REGS = 2 ** REGISTER_WIDTH;
  localparam logic [ROB_ENTRY_WIDTH-1:0] HEAD_LAST = ROB_ENTRY_WIDTH'(ROB_ENTRIES - 1);

  // register alias table
  logic [NUM_REGS-1:0]                      pend_q;
  logic [NUM_REGS-1:0][ROB_ENTRY_WIDTH-1:0] tag_q;
  logic [ROB_ENTRY_WIDTH-1:0]               head_q;

  // issue output register
  logic                       issue_valid_q;
  logic [ROB_ENTRY_WIDTH-1:0] issue_idx_q;
  logic [ADDR_WIDTH-1:0]      issue_pc_q;
  logic [REGISTER_WIDTH-1:0]  issue_rd_q;
  logic                       issue_p1_q;
  logic                       issue_p2_q;
  logic [ROB_ENTRY_WIDTH-1:0] issue_t1_q;
  logic [ROB_ENTRY_WIDTH-1:0] issue_t2_q;

  logic dec_ready;
  logic accept;
  logic commit_clear;
  logic alloc_rat;
  logic rs1_pend;
  logic rs2_pend;

  // Reset gates readiness so nothing is taken while rst_i is held.
  assign dec_ready = !rst_i && !bus.rob_full_i && (!issue_valid_q || bus.issue_ready_i);
  assign accept    = bus.dec_valid_i && dec_ready;

  // Only the head producer may clear a mapping; a younger producer of the same
  // register carries a different tag and keeps it.
  assign commit_clear = bus.commit_valid_i && bus.commit_is_wb_i
                     && (bus.commit_reg_id_i != '0)
                     && pend_q[bus.commit_reg_id_i]
                     && (tag_q[bus.commit_reg_id_i] == head_q);

  assign alloc_rat = accept && bus.dec_is_wb_i && (bus.dec_rd_i != '0);

  // Lookup sees the RAT before this cycle's allocation, with this cycle's clear bypassed.
  assign rs1_pend = (bus.dec_rs1_i != '0) && pend_q[bus.dec_rs1_i]
                 && !(commit_clear && (bus.commit_reg_id_i == bus.dec_rs1_i));
  assign rs2_pend = (bus.dec_rs2_i != '0) && pend_q[bus.dec_rs2_i]
                 && !(commit_clear && (bus.commit_reg_id_i == bus.dec_rs2_i));

  assign bus.dec_ready_o        = dec_ready;
  assign bus.rob_alloc_valid_o  = accept;
  assign bus.rob_alloc_is_wb_o  = bus.dec_is_wb_i;
  assign bus.rob_alloc_reg_id_o = bus.dec_rd_i;
  assign bus.rob_alloc_pc_o     = bus.dec_pc_i;

  assign bus.issue_valid_o       = issue_valid_q;
  assign bus.issue_rob_idx_o     = issue_idx_q;
  assign bus.issue_pc_o          = issue_pc_q;
  assign bus.issue_rd_o          = issue_rd_q;
  assign bus.issue_rs1_pending_o = issue_p1_q;
  assign bus.issue_rs2_pending_o = issue_p2_q;
  assign bus.issue_rs1_tag_o     = issue_t1_q;
  assign bus.issue_rs2_tag_o     = issue_t2_q;

  // RAT and head pointer. The allocate write follows the clear so that it wins
  // when both target the same register in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      tag_q  <= '0;
      head_q <= '0;
    end else begin
      if (bus.commit_valid_i) begin
        head_q <= (head_q == HEAD_LAST) ? '0 : head_q + 1'b1;
      end
      if (commit_clear) begin
        pend_q[bus.commit_reg_id_i] <= 1'b0;
      end
      if (alloc_rat) begin
        pend_q[bus.dec_rd_i] <= 1'b1;
        tag_q[bus.dec_rd_i]  <= bus.rob_new_idx_i;
      end
    end
  end

  // Issue register: loads on accept, drains on issue_ready_i, otherwise holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      issue_pc_q    <= '0;
      issue_rd_q    <= '0;
      issue_p1_q    <= 1'b0;
      issue_p2_q    <= 1'b0;
      issue_t1_q    <= '0;
      issue_t2_q    <= '0;
    end else if (accept) begin
      issue_valid_q <= 1'b1;
      issue_idx_q   <= bus.rob_new_idx_i;
      issue_pc_q    <= bus.dec_pc_i;
      issue_rd_q    <= bus.dec_rd_i;
      issue_p1_q    <= rs1_pend;
      issue_p2_q    <= rs2_pend;
      issue_t1_q    <= tag_q[bus.dec_rs1_i];
      issue_t2_q    <= tag_q[bus.dec_rs2_i];
    end else if (bus.issue_ready_i) begin
      issue_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dispatch_unit.sv
// tb/tb_dispatch_unit.sv - self-checking bench for dispatch_unit against an in-flight ROB model
module tb_dispatch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dispatch_unit_if bus ();

  dispatch_unit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: the ROB contents in program order; a source is pending when some
  // in-flight writer of it remains, and its tag is the youngest such writer.
  typedef struct {
    logic [3:0] idx;
    bit         wb;
    logic [4:0] rd;
  } ent_t;

  ent_t        rob_q[$];
  int          m_head = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic [4:0]  m_rd = '0;
  logic [3:0]  m_idx = '0;
  bit          m_p1 = 1'b0;
  bit          m_p2 = 1'b0;
  logic [3:0]  m_t1 = '0;
  logic [3:0]  m_t2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] rs, output bit p, output logic [3:0] t);
    p = 1'b0;
    t = '0;
    if (rs != 0) begin
      for (int i = 0; i < rob_q.size(); i++) begin
        if (rob_q[i].wb && rob_q[i].rd == rs) begin
          p = 1'b1;
          t = rob_q[i].idx;
        end
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rob_q.delete();
      m_head = 0;
      m_valid = 1'b0;
      m_pc = '0; m_rd = '0; m_idx = '0;
      m_p1 = 1'b0; m_p2 = 1'b0; m_t1 = '0; m_t2 = '0;
    end else begin
      bit   acc;
      ent_t e;
      acc = bus.dec_valid_i && !bus.rob_full_i && (!m_valid || bus.issue_ready_i);
      if (bus.commit_valid_i && rob_q.size() > 0) begin
        void'(rob_q.pop_front());
        m_head = (m_head + 1) % 16;
      end
      if (acc) begin
        lookup(bus.dec_rs1_i, m_p1, m_t1);
        lookup(bus.dec_rs2_i, m_p2, m_t2);
        m_pc  = bus.dec_pc_i;
        m_rd  = bus.dec_rd_i;
        m_idx = bus.rob_new_idx_i;
        e.idx = bus.rob_new_idx_i;
        e.wb  = bus.dec_is_wb_i;
        e.rd  = bus.dec_rd_i;
        rob_q.push_back(e);
        m_valid = 1'b1;
      end else if (bus.issue_ready_i) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit er;
      er = !rst && !bus.rob_full_i && (!m_valid || bus.issue_ready_i);
      chk("dec_ready", bus.dec_ready_o, er);
      chk("alloc_valid", bus.rob_alloc_valid_o, bus.dec_valid_i && er);
      if (bus.dec_valid_i && er) begin
        chk("alloc_pc", bus.rob_alloc_pc_o, bus.dec_pc_i);
        chk("alloc_is_wb", bus.rob_alloc_is_wb_o, bus.dec_is_wb_i);
        chk("alloc_reg", bus.rob_alloc_reg_id_o, bus.dec_rd_i);
      end
      chk("issue_valid", bus.issue_valid_o, m_valid);
      chk("issue_pc", bus.issue_pc_o, m_pc);
      chk("issue_rd", bus.issue_rd_o, m_rd);
      chk("issue_idx", bus.issue_rob_idx_o, m_idx);
      chk("rs1_pending", bus.issue_rs1_pending_o, m_p1);
      chk("rs2_pending", bus.issue_rs2_pending_o, m_p2);
      if (m_p1) chk("rs1_tag", bus.issue_rs1_tag_o, m_t1);
      if (m_p2) chk("rs2_tag", bus.issue_rs2_tag_o, m_t2);
    end
  end

  // Inputs follow the ROB model: new index is the tail, full at 16 in flight,
  // commits only retire a real head entry and carry its destination.
  task automatic drive(input bit v, input logic [31:0] pc, input bit wb,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit cv, input bit ff, input bit ir);
    bus.dec_valid_i   = v;
    bus.dec_pc_i      = pc;
    bus.dec_is_wb_i   = wb;
    bus.dec_rd_i      = rd;
    bus.dec_rs1_i     = rs1;
    bus.dec_rs2_i     = rs2;
    bus.rob_new_idx_i = 4'((m_head + rob_q.size()) % 16);
    bus.rob_full_i    = ff || (rob_q.size() >= 16);
    if (cv && rob_q.size() > 0) begin
      bus.commit_valid_i  = 1'b1;
      bus.commit_is_wb_i  = rob_q[0].wb;
      bus.commit_reg_id_i = rob_q[0].rd;
    end else begin
      bus.commit_valid_i  = 1'b0;
      bus.commit_is_wb_i  = 1'b0;
      bus.commit_reg_id_i = '0;
    end
    bus.issue_ready_i = ir;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("reset_issue_valid", bus.issue_valid_o, 1'b0);
    chk("reset_issue_pc", bus.issue_pc_o, 32'h0);

    // single dispatch
    drive(1'b1, 32'h100, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("t1_alloc_valid", bus.rob_alloc_valid_o, 1'b1);
    tick();
    chk("t1_issue_valid", bus.issue_valid_o, 1'b1);
    chk("t1_issue_idx", bus.issue_rob_idx_o, 4'd0);
    chk("t1_p1", bus.issue_rs1_pending_o, 1'b0);
    chk("t1_p2", bus.issue_rs2_pending_o, 1'b0);

    // dependency: filler at idx 1, I0 rd=5 at idx 2, I1 rs1=rs2=5 at idx 3
    drive(1'b1, 32'h104, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h108, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h10c, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1); tick();
    chk("t2_idx", bus.issue_rob_idx_o, 4'd3);
    chk("t2_p1", bus.issue_rs1_pending_o, 1'b1);
    chk("t2_t1", bus.issue_rs1_tag_o, 4'd2);
    chk("t2_p2", bus.issue_rs2_pending_o, 1'b1);
    chk("t2_t2", bus.issue_rs2_tag_o, 4'd2);

    // same-cycle commit bypass
    do_reset();
    drive(1'b1, 32'h200, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h204, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1); tick();
    chk("t3_p1_bypass", bus.issue_rs1_pending_o, 1'b0);
    drive(1'b1, 32'h208, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1); tick();
    chk("t3_p2_cleared", bus.issue_rs2_pending_o, 1'b0);

    // younger producer survives
    do_reset();
    drive(1'b1, 32'h300, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h304, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h308, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("t4_p1", bus.issue_rs1_pending_o, 1'b1);
    chk("t4_t1", bus.issue_rs1_tag_o, 4'd1);

    // back-pressure and ROB full
    do_reset();
    drive(1'b1, 32'h400, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h404, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t5_ready_bp", bus.dec_ready_o, 1'b0);
    chk("t5_alloc_bp", bus.rob_alloc_valid_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_valid", bus.issue_valid_o, 1'b1);
      chk("t5_hold_pc", bus.issue_pc_o, 32'h400);
      chk("t5_hold_rd", bus.issue_rd_o, 5'd6);
    end
    drive(1'b1, 32'h408, 1'b1, 5'd8, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_ready_full", bus.dec_ready_o, 1'b0);
    chk("t5_alloc_full", bus.rob_alloc_valid_o, 1'b0);
    tick();

    // head wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h500 + 32'(i * 4), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); tick();
    end
    drive(1'b1, 32'h600, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("t6_idx_wrap", bus.issue_rob_idx_o, 4'd0);
    drive(1'b1, 32'h604, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("t6_p1_before", bus.issue_rs1_pending_o, 1'b1);
    chk("t6_t1_before", bus.issue_rs1_tag_o, 4'd0);
    drive(1'b0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1); tick();
    drive(1'b1, 32'h608, 1'b0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("t6_p1_after", bus.issue_rs1_pending_o, 1'b0);

    // asynchronous reset mid-stream
    do_reset();
    drive(1'b1, 32'h700, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1); tick();
    chk("t7_valid_pre", bus.issue_valid_o, 1'b1);
    drive(1'b1, 32'h704, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid", bus.issue_valid_o, 1'b0);
    chk("t7_async_pc", bus.issue_pc_o, 32'h0);
    chk("t7_async_ready", bus.dec_ready_o, 1'b0);
    chk("t7_async_alloc", bus.rob_alloc_valid_o, 1'b0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom % 2,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom % 2) != 0, ($urandom % 10) == 0, ($urandom % 4) != 0);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
